perf_counter_bank: RTL
======================

Name: perf_counter_bank

Overview:
- Bank of eight event counters that feed the memory-mapped performance window at 16'hFFF8–16'hFFFF: icache hit/miss, dcache hit/miss, L2 hit/miss, branch count, branch mispredicts.
- Acts as the responder on the read/write/address/resp memory handshake for that window.
  - Reads return a counter.
  - Writes load or clear a counter.
- Sits beside the memory-side address decode. Takes one-cycle event pulses from the caches and branch unit.

Parameters:
- CTR_WIDTH, 16, counter width; legal 8..16. rdata is zero-extended above CTR_WIDTH.
- BASE_ADDR, 16'hFFF8, first address of the window; must be 8-aligned.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- count_en  in  1  global count enable; 0 freezes all counting
- icache_hit_ev  in  1  one-cycle icache hit pulse
- icache_miss_ev  in  1  one-cycle icache miss pulse
- dcache_hit_ev  in  1  one-cycle dcache hit pulse
- dcache_miss_ev  in  1  one-cycle dcache miss pulse
- l2_hit_ev  in  1  one-cycle L2 hit pulse
- l2_miss_ev  in  1  one-cycle L2 miss pulse
- br_ev  in  1  one-cycle pulse per resolved branch
- br_mispredict_ev  in  1  one-cycle pulse per mispredict
- read  in  1  memory read request
- write  in  1  memory write request
- address  in  16  request address (lc3b_word)
- wdata  in  16  write data (lc3b_word)
- rdata  out  16  read data, valid while resp=1
- resp  out  1  one-cycle response
- hit  out  1  combinational: address is in window and (read|write); the upstream mux uses it to suppress the pass-through request

Behaviour:
- Reset: asynchronous on reset_n=0.
  - All counters = 0, rdata = 0, resp = 0, FSM = IDLE.
  - Reset mid-transaction aborts it; no resp is issued.
- Counter index = address[2:0]. Window = address[15:3] == BASE_ADDR[15:3].
  - Index map: 0 icache_hit, 1 icache_miss, 2 dcache_hit, 3 dcache_miss, 4 l2_hit, 5 l2_miss, 6 br, 7 br_mispredict.
- Counting:
  - Each edge, counter i increments by 1 if its event=1 and count_en=1.
  - Events on different counters in the same cycle all count.
  - Default wraps from all-ones to 0; see the optional feature.
- FSM states: IDLE, RESP, WAIT.
  - IDLE: if hit, latch index.
    - Write: counter[index] <= wdata[CTR_WIDTH-1:0] on that edge.
    - Read: rdata <= counter[index], the value before this edge's increment.
    - Go to RESP.
    - Read and write both high: treat as read, no write.
    - Outside the window: ignored, stay in IDLE, resp stays 0.
  - RESP: resp=1 for exactly one cycle; rdata held. Go to WAIT.
  - WAIT: resp=0. Return to IDLE when read=0 and write=0. This prevents a held request from being serviced twice.
- Latency: request seen at edge N, resp high in cycle N+1. Back-to-back requests need a deasserted cycle between them.
- Write vs event on the same counter at the same edge: write wins and the event is lost.
- rdata holds its last read value outside RESP. Writes do not update rdata.

Optional Feature:
- Macro PERF_SATURATE_EN.
- Defined: counters stick at 2^CTR_WIDTH-1 and further events are ignored. Only a write or reset leaves saturation.
- Undefined: counters wrap modulo 2^CTR_WIDTH.

Decomposition:
- lc3b_types package:
  - lc3b_word.
  - perf_idx_t enum (PERF_ICACHE_HIT=0 … PERF_BR_MISPREDICT=7).
  - PERF_BASE_ADDR = 16'hFFF8 constant.
- Sub-module perf_counter: one counter with clk, reset_n, inc, load, load_val, count. Holds the saturate/wrap logic; instantiated 8 times.
- FSM and read mux live in perf_counter_bank.

Test Plan:
- Reset, then 5 icache_hit_ev pulses with count_en=1; read 16'hFFF8 -> resp one cycle later, rdata=5. Other counters read 0.
- 3 br_ev pulses with count_en=0, then 2 with count_en=1; read 16'hFFFE -> rdata=2.
- Write 16'hFFF9 with wdata=16'h1234, then one icache_miss_ev; read -> 16'h1235. Write with an event on the same edge -> value equals wdata exactly.
- Load 16'hFFFF with 16'hFFFF, then one br_mispredict_ev. Read -> 16'h0000 (wrap), or 16'hFFFF with PERF_SATURATE_EN.
- Hold read at 16'hFFFA for 6 cycles -> exactly one resp pulse. Read at 16'hFFF7 -> hit=0, no resp, counters unchanged.
- Assert reset_n=0 in the RESP cycle -> resp=0 immediately, all counters 0. Next request is serviced normally from IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b word type, performance-counter index map, window base address
// and the responder state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        PERF_ICACHE_HIT    = 3'd0,
        PERF_ICACHE_MISS   = 3'd1,
        PERF_DCACHE_HIT    = 3'd2,
        PERF_DCACHE_MISS   = 3'd3,
        PERF_L2_HIT        = 3'd4,
        PERF_L2_MISS       = 3'd5,
        PERF_BR            = 3'd6,
        PERF_BR_MISPREDICT = 3'd7
    } perf_idx_t;

    localparam lc3b_word PERF_BASE_ADDR = 16'hFFF8;
    localparam int       PERF_NUM_CTRS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WAIT = 2'd2
    } perf_state_t;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with synchronous load; wraps by default, or sticks at
// all-ones when PERF_SATURATE_EN is defined.
module perf_counter #(
    parameter int CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 load,
    input  logic [CTR_WIDTH-1:0] load_val,
    output logic [CTR_WIDTH-1:0] count
);

    // A load on the same edge as an event takes priority; the event is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
`ifdef PERF_SATURATE_EN
            if (count != '1) begin
                count <= count + 1'b1;
            end
`else
            count <= count + 1'b1;
`endif
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Eight event counters exposed as a read/write window on the memory bus.
// Build option: PERF_SATURATE_EN makes counters saturate instead of wrapping.
module perf_counter_bank
    import lc3b_types::*;
#(
    parameter int       CTR_WIDTH = 16,
    parameter lc3b_word BASE_ADDR = PERF_BASE_ADDR
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     count_en,
    input  logic     icache_hit_ev,
    input  logic     icache_miss_ev,
    input  logic     dcache_hit_ev,
    input  logic     dcache_miss_ev,
    input  logic     l2_hit_ev,
    input  logic     l2_miss_ev,
    input  logic     br_ev,
    input  logic     br_mispredict_ev,
    input  logic     read,
    input  logic     write,
    input  lc3b_word address,
    input  lc3b_word wdata,
    output lc3b_word rdata,
    output logic     resp,
    output logic     hit
);

    // Handshake: a request (read or write held high with a stable address) is
    // taken in IDLE when hit=1; resp pulses high for exactly one cycle on the
    // next cycle, and the requester must drop read/write before another
    // request is taken, so a held request is serviced only once.

    perf_state_t            state;
    logic [7:0]             ev;
    logic [2:0]             idx;
    logic                   in_window;
    logic                   wr_accept;
    logic [CTR_WIDTH-1:0]   counts [PERF_NUM_CTRS];

    assign idx       = address[2:0];
    assign in_window = (address[15:3] == BASE_ADDR[15:3]);
    assign hit       = in_window && (read || write);
    // Read has priority when both strobes are high.
    assign wr_accept = (state == ST_IDLE) && hit && write && !read;

    always_comb begin
        ev                     = '0;
        ev[PERF_ICACHE_HIT]    = icache_hit_ev;
        ev[PERF_ICACHE_MISS]   = icache_miss_ev;
        ev[PERF_DCACHE_HIT]    = dcache_hit_ev;
        ev[PERF_DCACHE_MISS]   = dcache_miss_ev;
        ev[PERF_L2_HIT]        = l2_hit_ev;
        ev[PERF_L2_MISS]       = l2_miss_ev;
        ev[PERF_BR]            = br_ev;
        ev[PERF_BR_MISPREDICT] = br_mispredict_ev;
    end

    for (genvar g = 0; g < PERF_NUM_CTRS; g++) begin : g_ctr
        perf_counter #(
            .CTR_WIDTH(CTR_WIDTH)
        ) u_ctr (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (ev[g] && count_en),
            .load    (wr_accept && (idx == 3'(g))),
            .load_val(wdata[CTR_WIDTH-1:0]),
            .count   (counts[g])
        );
    end

    // rdata captures the counter value from before this edge's increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            rdata <= '0;
            resp  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp <= 1'b0;
                    if (hit) begin
                        if (read) begin
                            rdata <= 16'(counts[idx]);
                        end
                        resp  <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp  <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    resp <= 1'b0;
                    if (!read && !write) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    resp  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
